// File: rtl/composite_dac_enc.sv
// Composite-video DAC stage: mixes pixel flags and timing strobes into an 8-bit
// level with a triangle colour-burst, plus a first-order sigma-delta output.
module composite_dac_enc #(
  parameter int unsigned C_SYNC_LV    = 0,
  parameter int unsigned C_BLANK_LV   = 76,
  parameter int unsigned C_BLACK_LV   = 82,
  parameter int unsigned C_FUCHI_LV   = 140,
  parameter int unsigned C_WHITE_LV   = 255,
  parameter int unsigned C_BURST_STEP = 2,
  parameter int unsigned C_BURST_PH   = 0
) (
  input  logic       FSC32_CK_i,
  input  logic       SYS_R_i,
  input  logic       VIDEO_i,
  input  logic       FUCHI_i,
  input  logic       XSYNC_i,
  input  logic       BLANK_i,
  input  logic       BURST_i,
  output logic [7:0] DAC_Ds_o,
  output logic       SD_o,
  output logic [4:0] PH_o
);

  localparam logic signed [9:0] BLANK_S = 10'(C_BLANK_LV);
  localparam logic signed [9:0] STEP_S  = 10'(C_BURST_STEP);

  localparam int unsigned F_VIDEO = 4;
  localparam int unsigned F_FUCHI = 3;
  localparam int unsigned F_XSYNC = 2;
  localparam int unsigned F_BLANK = 1;
  localparam int unsigned F_BURST = 0;

  logic [4:0]        ph_q, ph_d;
  logic [4:0]        p_q, p_d;
  logic [4:0]        flags_q, flags_d;
  logic [7:0]        dac_q, dac_d;
  logic [7:0]        acc_q, acc_d;
  logic              sd_q, sd_d;

  logic [4:0]        tri_val;
  logic signed [9:0] burst_off;
  logic signed [9:0] burst_lvl;
  logic [7:0]        burst_code;

  always_comb begin
    ph_d    = ph_q + 5'd1;
    p_d     = ph_q + 5'(C_BURST_PH);
    flags_d = {VIDEO_i, FUCHI_i, XSYNC_i, BLANK_i, BURST_i};

    // Burst offset is signed around the blanking level; clamp keeps large
    // negative swings at code 0 instead of wrapping to bright codes.
    tri_val   = p_q[4] ? (5'd31 - p_q) : p_q;
    burst_off = (signed'({5'b0, tri_val}) - 10'sd8) * STEP_S;
    burst_lvl = BLANK_S + burst_off;
    if (burst_lvl < 10'sd0) begin
      burst_code = '0;
    end else if (burst_lvl > 10'sd255) begin
      burst_code = '1;
    end else begin
      burst_code = burst_lvl[7:0];
    end

    if (!flags_q[F_XSYNC]) begin
      dac_d = 8'(C_SYNC_LV);
    end else if (flags_q[F_BLANK] && flags_q[F_BURST]) begin
      dac_d = burst_code;
    end else if (flags_q[F_BLANK]) begin
      dac_d = 8'(C_BLANK_LV);
    end else if (flags_q[F_VIDEO]) begin
      dac_d = 8'(C_WHITE_LV);
    end else if (flags_q[F_FUCHI]) begin
      dac_d = 8'(C_FUCHI_LV);
    end else begin
      dac_d = 8'(C_BLACK_LV);
    end

    {sd_d, acc_d} = {1'b0, acc_q} + {1'b0, dac_q};
  end

  always_ff @(posedge FSC32_CK_i or posedge SYS_R_i) begin
    if (SYS_R_i) begin
      ph_q    <= '0;
      p_q     <= '0;
      flags_q <= '0;
      dac_q   <= '0;
      acc_q   <= '0;
      sd_q    <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      p_q     <= p_d;
      flags_q <= flags_d;
      dac_q   <= dac_d;
      acc_q   <= acc_d;
      sd_q    <= sd_d;
    end
  end

  assign DAC_Ds_o = dac_q;
  assign SD_o     = sd_q;
  assign PH_o     = ph_q;

endmodule
